uart_rx_mmio: RTL and testbench

- Receive-side counterpart of the UART transmit MMIO adapter.
- Deserialises an 8N1 UART line into a small byte FIFO.
- Exposes a CPU load interface at the same UART base address: the data register pops a byte, and a line-status register reports data-ready, overrun and framing errors.
- Sits between the core's load path and the off-chip rx pin.

---
 rtl/uart_rx_mmio.sv | 111 +++++++++++
 tb/tb_uart_rx_mmio.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 8N1 UART receiver with byte FIFO behind a CPU load interface (RBR/LSR)
module uart_rx_mmio #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [63:0] RBR_ADDR     = 64'h1000_0000,
  parameter logic [63:0] LSR_ADDR     = 64'h1000_0005
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_serial,
  input  logic        i_ren,
  input  logic [63:0] address,
  output logic [63:0] o_rdata,
  output logic        o_hit,
  output logic        rx_irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shreg, shreg_n;
  logic [1:0] sync;
  logic rx_s, stop_done;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic empty, full, rbr_sel, lsr_sel, pop, push, oe_set, fe_set, oe, fe;
  assign rx_s = sync[1];
  // two-flop synchroniser on the asynchronous line, idles high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 2'b11;
    else sync <= {sync[0], rx_serial};
  // receiver state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  // next-state: mid-start validation, then one sample per bit period
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    stop_done = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START:
        if (cnt == CW'(CLKS_PER_BIT/2 - 1)) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      DATA:
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      STOP:
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_n     = '0;
          stop_done = 1'b1;
          state_n   = IDLE;
        end
    endcase
  end
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rbr_sel  = i_ren && address == RBR_ADDR;
  assign lsr_sel  = i_ren && address == LSR_ADDR;
  assign pop      = rbr_sel && !empty;
  assign push     = stop_done && rx_s && (!full || pop);
  assign oe_set   = stop_done && rx_s && full && !pop;
  assign fe_set   = stop_done && !rx_s;
  assign wr_ptr_n = wr_ptr + (AW+1)'(push);
  assign rd_ptr_n = rd_ptr + (AW+1)'(pop);
  // FIFO pointers, sticky error flags (new error beats LSR clear), irq
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      oe     <= 1'b0;
      fe     <= 1'b0;
      rx_irq <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      oe     <= oe_set | (oe & !lsr_sel);
      fe     <= fe_set | (fe & !lsr_sel);
      rx_irq <= wr_ptr_n != rd_ptr_n;
    end
  // FIFO storage, no reset needed since pointers gate visibility
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  assign o_hit   = rbr_sel | lsr_sel;
  assign o_rdata = pop     ? {56'b0, mem[rd_ptr[AW-1:0]]} :
                   lsr_sel ? {56'b0, 4'b0, fe, 1'b0, oe, !empty} : '0;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: directed self-checking bench for the UART receive MMIO block
module tb_uart_rx_mmio;
  localparam logic [63:0] RBR = 64'h1000_0000;
  localparam logic [63:0] LSR = 64'h1000_0005;
  logic clk = 1'b0, rst_n = 1'b0, rx_serial = 1'b1, i_ren = 1'b0;
  logic [63:0] address = '0, o_rdata;
  logic o_hit, rx_irq;
  int n_checks = 0, n_fail = 0;
  uart_rx_mmio dut (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .i_ren(i_ren),
    .address(address), .o_rdata(o_rdata), .o_hit(o_hit), .rx_irq(rx_irq)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic load(input string tag, input logic [63:0] addr, input logic [63:0] exp);
    i_ren = 1'b1;
    address = addr;
    #1;
    check(tag, o_rdata, exp);
    check({tag, "_hit"}, 64'(o_hit), 64'd1);
    tick;
    i_ren = 1'b0;
    address = '0;
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    rx_serial = 1'b0;
    repeat (16) tick;
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (16) tick;
    end
    rx_serial = stop;
    repeat (16) tick;
    rx_serial = 1'b1;
  endtask
  initial begin
    repeat (3) tick;
    check("rst_irq", 64'(rx_irq), 64'd0);
    check("rst_rdata", o_rdata, 64'd0);
    check("rst_hit", 64'(o_hit), 64'd0);
    rst_n = 1'b1;
    tick;
    load("lsr_idle", LSR, 64'h00);
    fork
      send(8'hA5, 1'b1);
      begin
        repeat (154) tick;
        check("irq_before_stop", 64'(rx_irq), 64'd0);
        tick;
        check("irq_after_stop", 64'(rx_irq), 64'd1);
      end
    join
    repeat (4) tick;
    i_ren = 1'b1;
    address = 64'h1000_0001;
    #1;
    check("other_rdata", o_rdata, 64'd0);
    check("other_hit", 64'(o_hit), 64'd0);
    tick;
    i_ren = 1'b0;
    address = RBR;
    #1;
    check("noren_rdata", o_rdata, 64'd0);
    check("noren_hit", 64'(o_hit), 64'd0);
    tick;
    load("lsr_a5", LSR, 64'h01);
    load("rbr_a5", RBR, 64'hA5);
    load("lsr_after_pop", LSR, 64'h00);
    check("irq_after_pop", 64'(rx_irq), 64'd0);
    rx_serial = 1'b0;
    repeat (5) tick;
    rx_serial = 1'b1;
    repeat (40) tick;
    load("lsr_glitch", LSR, 64'h00);
    check("irq_glitch", 64'(rx_irq), 64'd0);
    send(8'h3C, 1'b0);
    repeat (20) tick;
    load("lsr_fe", LSR, 64'h08);
    load("lsr_fe_clr", LSR, 64'h00);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    send(8'h55, 1'b1);
    repeat (20) tick;
    load("lsr_oe", LSR, 64'h03);
    load("rbr_11", RBR, 64'h11);
    load("rbr_22", RBR, 64'h22);
    load("rbr_33", RBR, 64'h33);
    load("rbr_44", RBR, 64'h44);
    load("rbr_empty", RBR, 64'h00);
    load("lsr_drained", LSR, 64'h00);
    send(8'h21, 1'b1);
    send(8'h32, 1'b1);
    send(8'h43, 1'b1);
    send(8'h54, 1'b1);
    fork
      send(8'h66, 1'b1);
      begin
        repeat (154) tick;
        load("rbr_race", RBR, 64'h21);
      end
    join
    repeat (20) tick;
    load("lsr_race", LSR, 64'h01);
    load("rbr_32", RBR, 64'h32);
    load("rbr_43", RBR, 64'h43);
    load("rbr_54", RBR, 64'h54);
    load("rbr_66", RBR, 64'h66);
    load("lsr_race_done", LSR, 64'h00);
    send(8'h5A, 1'b1);
    repeat (4) tick;
    check("irq_pre_reset", 64'(rx_irq), 64'd1);
    rx_serial = 1'b0;
    repeat (16) tick;
    rx_serial = 1'b0;
    repeat (16) tick;
    rx_serial = 1'b1;
    repeat (32) tick;
    repeat (8) tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("irq_async_rst", 64'(rx_irq), 64'd0);
    i_ren = 1'b1;
    address = LSR;
    #1;
    check("lsr_in_rst", o_rdata, 64'd0);
    address = RBR;
    #1;
    check("rbr_in_rst", o_rdata, 64'd0);
    i_ren = 1'b0;
    address = '0;
    rx_serial = 1'b1;
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (20) tick;
    load("lsr_post_rst", LSR, 64'h00);
    send(8'h81, 1'b1);
    repeat (4) tick;
    load("lsr_81", LSR, 64'h01);
    load("rbr_81", RBR, 64'h81);
    load("rbr_81_empty", RBR, 64'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
